// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing the register-file write port among NUM_REQ sources.
// Optional build macro WB_ARB_RR_EN selects round-robin instead of fixed priority.
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_WAIT = 4,
  parameter int AW       = 5,
  parameter int DW       = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wb_hold,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  wr_ch0_en,
  output logic [AW-1:0]         wr_ch0_addr,
  output logic [DW-1:0]         wr_ch0_data,
  output logic                  arb_busy
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0]      r_wait_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] w_grant;
  logic               w_found;
  logic [IW-1:0]      w_gidx;
  logic [AW-1:0]      w_addr;
  logic [DW-1:0]      w_data;
  logic               r_en;
  logic [AW-1:0]      r_addr;
  logic [DW-1:0]      r_data;

`ifdef WB_ARB_RR_EN
  logic [IW-1:0]      r_rr_ptr;
`endif

  // Starvation override first; the normal policy only runs if nobody is starved.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    if (reset_n && !wb_hold) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_found && req_valid[i] && r_wait_cnt[i] == CNT_MAX) begin
          w_found = 1'b1;
          w_gidx  = IW'(i);
        end
      end
`ifdef WB_ARB_RR_EN
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        int unsigned j;
        j = (int'(r_rr_ptr) + k) % NUM_REQ;
        if (!w_found && req_valid[j]) begin
          w_found = 1'b1;
          w_gidx  = IW'(j);
        end
      end
`else
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_found && req_valid[i]) begin
          w_found = 1'b1;
          w_gidx  = IW'(i);
        end
      end
`endif
      if (w_found) w_grant[w_gidx] = 1'b1;
    end
  end

  assign w_addr    = req_addr[w_gidx*AW +: AW];
  assign w_data    = req_data[w_gidx*DW +: DW];
  assign req_ready = w_grant;
  assign arb_busy  = |req_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_wait_cnt[i] <= '0;
    end else if (!wb_hold) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || w_grant[i]) r_wait_cnt[i] <= '0;
        else if (r_wait_cnt[i] != CNT_MAX) r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
      end
    end
  end

`ifdef WB_ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (w_found) begin
      r_rr_ptr <= (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
    end
  end
`endif

  // x0 requests complete the handshake but never raise the write enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_en <= w_found && (w_addr != '0);
      if (w_found) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  end

  assign wr_ch0_en   = r_en;
  assign wr_ch0_addr = r_addr;
  assign wr_ch0_data = r_data;

endmodule
